// File: rtl/bin2bcd_converter.sv
// Double-dabble binary-to-BCD converter with leading-zero digit mask and overflow flag.
// Latency WIDTH+2 cycles from accepted start to done; start while busy is dropped, results held until next done.
module bin2bcd_converter #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      numb,
  input  logic                  start,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     mask,
  output logic                  overflow,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    bin_q, bin_d;
  logic [BW-1:0]       scr_q, scr_d;
  logic                sticky_q, sticky_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BW-1:0]       bcd_q, bcd_d;
  logic [DIGITS-1:0]   mask_q, mask_d;
  logic                ovf_q, ovf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [BW-1:0]       adj;
  logic [DIGITS-1:0]   mask_calc;
  logic                any_nz;

  // Add-3 correction: digits of 5..9 become 8..12, so the shift carries correctly.
  always_comb begin
    adj = scr_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (scr_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    any_nz    = 1'b0;
    mask_calc = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      any_nz       = any_nz | (scr_q[4*i +: 4] != 4'd0);
      mask_calc[i] = any_nz;
    end
    mask_calc[0] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    bin_d    = bin_q;
    scr_d    = scr_q;
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    bcd_d    = bcd_q;
    mask_d   = mask_q;
    ovf_d    = ovf_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d    = numb;
          scr_d    = '0;
          sticky_d = 1'b0;
          cnt_d    = '0;
          busy_d   = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        // The bit leaving the top digit is a multiple of 10^DIGITS; keep it only as overflow.
        scr_d    = {adj[BW-2:0], bin_q[WIDTH-1]};
        bin_d    = bin_q << 1;
        sticky_d = sticky_q | adj[BW-1];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        bcd_d   = scr_q;
        ovf_d   = sticky_q;
        mask_d  = sticky_q ? '1 : mask_calc;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      scr_q    <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
      bcd_q    <= '0;
      mask_q   <= DIGITS'(1);
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bin_q    <= bin_d;
      scr_q    <= scr_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
      bcd_q    <= bcd_d;
      mask_q   <= mask_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bcd      = bcd_q;
  assign mask     = mask_q;
  assign overflow = ovf_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: doc/bin2bcd_converter.md
# bin2bcd_converter

Sequential shift-add-3 (double-dabble) converter that takes the 32-bit binary value held by the entry shift register and produces packed BCD digits plus a leading-zero digit mask for the 7-segment scan controller. It sits between `shift_reg` and `segment_controller` in the 100 MHz domain. It converts one value per `start` request and holds the result until the next conversion completes. Values wider than the display are flagged with `overflow`.

## Interface
Parameters:
- `WIDTH`, 32: width of the binary input.
- `DIGITS`, 8: number of BCD digits produced, which is also the mask width.

Ports:
- `clk`, input, 1: system clock, `clk100mhz` domain.
- `reset`, input, 1: synchronous, active-high reset.
- `numb`, input, WIDTH: binary value to convert. It is sampled only on an accepted `start`.
- `start`, input, 1: conversion request, a single-cycle pulse such as `enter_sync_enable`. A level input is also tolerated.
- `bcd`, output, 4*DIGITS: packed BCD result. Digit 0 is `bcd[3:0]` and is the least significant digit.
- `mask`, output, DIGITS: digit enable. 1 means the digit is lit.
- `overflow`, output, 1: set when the last converted value is ≥ 10^DIGITS.
- `busy`, output, 1: high while a conversion is in progress.
- `done`, output, 1: one-cycle pulse marking the cycle in which new results first appear.

## Operation
- FSM states: IDLE, SHIFT, FINISH.
- **IDLE:**
  - `start`=1 latches `numb` into a shift register.
  - It also clears the BCD scratch register, the sticky overflow bit and the iteration counter, then moves to SHIFT.
- **SHIFT**, exactly WIDTH cycles. Each cycle:
  - Every scratch digit ≥ 5 gets +3.
  - Then the scratch register shifts left by 1. Binary MSB enters at the scratch LSB, and the binary register shifts left.
  - The bit shifted out of the top scratch digit is ORed into the sticky overflow bit.
  - When the counter reaches WIDTH-1, the FSM moves to FINISH.
- **FINISH**, 1 cycle:
  - `bcd` ← scratch, which is the value mod 10^DIGITS.
  - `overflow` ← sticky bit.
  - `mask` ← computed from scratch:
    - If overflow: all ones.
    - Otherwise: bit i=1 for every i ≤ index of the most significant nonzero digit.
    - Bit 0 is always 1, so the value 0 shows a single "0".
  - `done` is registered to 1, and the FSM returns to IDLE.
- `start` while `busy`=1 is ignored; it is neither queued nor restarts the conversion.
- `numb` changes during a conversion have no effect.
- `bcd`, `mask` and `overflow` change only in the update cycle and are held otherwise.
- Scratch digits never exceed 12 after the +3 adjust, so 4 bits per digit are sufficient.
- Dropping the top bit is equivalent to subtracting 10^DIGITS, so `bcd` always equals value mod 10^DIGITS.

## Timing
- All outputs are registered, with no combinational input-to-output path.
- Reset values:
  - `bcd` = 0
  - `mask` = {{DIGITS-1{0}},1}
  - `overflow` = 0
  - `busy` = 0
  - `done` = 0
  - FSM = IDLE
- Conversion sequence, with `start` sampled high in IDLE at cycle N:
  - `busy`=1 from cycle N+1 through N+WIDTH+1.
  - At cycle N+WIDTH+2, `done`=1, `busy`=0 and the new `bcd`/`mask`/`overflow` are visible.
- Latency from `start` to `done` is WIDTH+2 cycles, which is 34 for the default WIDTH.
- A `start` in the `done` cycle is accepted, because the FSM is already in IDLE. Back-to-back throughput is one conversion per WIDTH+2 cycles.
- `done` is high for exactly one cycle per accepted `start`.
- Reset asserted mid-conversion aborts it. The next cycle shows all outputs at their reset values, and no `done` is produced.
- Reset and `start` in the same cycle: reset wins and `start` is dropped.

## Test plan
- After reset, with no start: `bcd`=0x00000000, `mask`=0x01, `overflow`=0, `busy`=0, `done`=0.
- Zero and short values:
  - `numb`=0, start: `done` 34 cycles later, `bcd`=0x00000000, `mask`=0x01, `overflow`=0.
  - `numb`=1000: `bcd`=0x00001000, `mask`=0x0F.
- Eight-digit values with no overflow:
  - `numb`=0x00BC614E (12345678): `bcd`=0x12345678, `mask`=0xFF, `overflow`=0.
  - `numb`=0x05F5E0FF (99999999): `bcd`=0x99999999, `overflow`=0.
- Overflow cases:
  - `numb`=0x05F5E100 (100000000): `bcd`=0x00000000, `overflow`=1, `mask`=0xFF.
  - `numb`=0xFFFFFFFF: `bcd`=0x94967295, `overflow`=1.
- Start while busy: start with 0x7B (123), pulse `start` with 0x1C8 (456) at cycle N+10, and change `numb` mid-run.
  - Required: exactly one `done`, at N+34, with `bcd`=0x00000123 and `mask`=0x07.
  - A start in the `done` cycle yields a second `done` 34 cycles later.
- Reset mid-conversion: assert `reset` at cycle N+20.
  - Required: outputs at reset values the next cycle, `busy`=0, and no `done` for the next 40 cycles.
  - A subsequent conversion of 42 gives `bcd`=0x00000042, `mask`=0x03.
